// File: rtl/seg_pkg.sv
// Shared segment definitions: pattern constants, segment bit indices and decoder FSM states.
// Also used by the hex-to-segment display driver.
package seg_pkg;

    localparam int SEG_W = 7;
    localparam int DIG_W = 2;

    // After pin inversion, segment A sits in the MSB and G in the LSB.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_PAT_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_PAT_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_PAT_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_PAT_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_PAT_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_PAT_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_PAT_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_PAT_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_PAT_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_PAT_9 = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_PAT_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_PAT_B = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_PAT_C = 7'h0D;
    localparam logic [SEG_W-1:0] SEG_PAT_D = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_PAT_E = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_PAT_F = 7'h47;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    // Synchronized, active-high snapshot of all display pins.
    typedef struct packed {
        logic [DIG_W-1:0] dig_en;
        logic [SEG_W-1:0] seg;
    } snap_t;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0:    return SEG_PAT_0;
            4'h1:    return SEG_PAT_1;
            4'h2:    return SEG_PAT_2;
            4'h3:    return SEG_PAT_3;
            4'h4:    return SEG_PAT_4;
            4'h5:    return SEG_PAT_5;
            4'h6:    return SEG_PAT_6;
            4'h7:    return SEG_PAT_7;
            4'h8:    return SEG_PAT_8;
            4'h9:    return SEG_PAT_9;
            4'hA:    return SEG_PAT_A;
            4'hB:    return SEG_PAT_B;
            4'hC:    return SEG_PAT_C;
            4'hD:    return SEG_PAT_D;
            4'hE:    return SEG_PAT_E;
            default: return SEG_PAT_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_lookup.sv
// Reverse segment lookup: 7-bit active-high pattern -> {hit, hex value}. Purely combinational.
module seg_lookup
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             hit,
    output logic [3:0]       value
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit   = 1'b0;
        value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (hex_to_seg(4'(i)) == seg) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_decode.sv
// Recovers hex digits from a two-digit multiplexed 7-segment display by sampling stable pin windows.
// Optional SEG_DECODE_ERRCNT_EN adds a saturating 8-bit err_cnt output.
module seg_decode
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEG_W-1:0] seg_n,
    input  logic [DIG_W-1:0] dig_en_n,
    output logic [3:0]       hex0,
    output logic [3:0]       hex1,
    output logic             valid0,
    output logic             valid1,
    output logic             upd,
    output logic             upd_idx,
    output logic             err
`ifdef SEG_DECODE_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int          SNAP_W  = DIG_W + SEG_W;
    localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES);

    logic [SNAP_W-1:0] sync_q1, sync_q2;
    snap_t             snap, snap_prev;
    logic [7:0]        cnt, cnt_next;
    state_t            state, state_next;
    logic              change, capture;
    logic              hit;
    logic [3:0]        value;

    // Pins idle high, so the synchronizer resets to all-ones (display inactive).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1   <= '1;
            sync_q2   <= '1;
            snap_prev <= '0;
            cnt       <= '0;
            state     <= ST_SETTLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync_q1   <= {dig_en_n, seg_n};
            sync_q2   <= sync_q1;
            snap_prev <= snap;
            cnt       <= cnt_next;
            state     <= state_next;
        end
    end

    assign snap   = snap_t'(~sync_q2);
    assign change = (snap != snap_prev);

    // The FSM looks at the next count so CAPTURE lands on the edge the counter reaches the limit.
    always_comb begin
        cnt_next   = cnt;
        state_next = state;
        if (change)
            cnt_next = '0;
        else if (cnt != CNT_MAX)
            cnt_next = cnt + 8'd1;

        unique case (state)
            ST_SETTLE:  if (cnt_next == CNT_MAX) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_HOLD;
            ST_HOLD:    state_next = ST_HOLD;
            default:    state_next = ST_SETTLE;
        endcase

        if (change)
            state_next = ST_SETTLE;
    end

    // A change arriving in the CAPTURE cycle breaks the window, so nothing is taken.
    assign capture = (state == ST_CAPTURE) && !change;

    seg_lookup u_lookup (
        .seg   (snap.seg),
        .hit   (hit),
        .value (value)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex0    <= 4'h0;
            hex1    <= 4'h0;
            valid0  <= 1'b0;
            valid1  <= 1'b0;
            upd     <= 1'b0;
            upd_idx <= 1'b0;
            err     <= 1'b0;
        end else begin
            upd <= 1'b0;
            err <= 1'b0;
            if (capture) begin
                unique case (snap.dig_en)
                    2'b01: begin
                        if (hit) begin
                            hex0    <= value;
                            valid0  <= 1'b1;
                            upd     <= 1'b1;
                            upd_idx <= 1'b0;
                        end else begin
                            valid0  <= 1'b0;
                            err     <= 1'b1;
                        end
                    end
                    2'b10: begin
                        if (hit) begin
                            hex1    <= value;
                            valid1  <= 1'b1;
                            upd     <= 1'b1;
                            upd_idx <= 1'b1;
                        end else begin
                            valid1  <= 1'b0;
                            err     <= 1'b1;
                        end
                    end
                    2'b11:   err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef SEG_DECODE_ERRCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt <= 8'd0;
        else if (err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_seg_decode.sv
// Directed self-checking bench for seg_decode (STABLE_CYCLES=16); err_cnt checks run when
// SEG_DECODE_ERRCNT_EN is defined.
module tb_seg_decode;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg_n = 7'h7F;
    logic [1:0] dig_en_n = 2'b11;
    logic [3:0] hex0, hex1;
    logic       valid0, valid1, upd, upd_idx, err;
`ifdef SEG_DECODE_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_upd, n_err, first_upd, first_err, last_idx;

    seg_decode #(.STABLE_CYCLES(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .seg_n    (seg_n),
        .dig_en_n (dig_en_n),
        .hex0     (hex0),
        .hex1     (hex1),
        .valid0   (valid0),
        .valid1   (valid1),
        .upd      (upd),
        .upd_idx  (upd_idx),
        .err      (err)
`ifdef SEG_DECODE_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_upd     = 0;
        n_err     = 0;
        first_upd = -1;
        first_err = -1;
        last_idx  = -1;
    endtask

    // Runs n clock edges, sampling 1 time unit after each rising edge; edge 1 is the first
    // edge that samples pins driven before the call.
    task automatic run(input int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) begin
                n_upd++;
                last_idx = int'(upd_idx);
                if (first_upd < 0) first_upd = i;
            end
            if (err === 1'b1) begin
                n_err++;
                if (first_err < 0) first_err = i;
            end
        end
    endtask

    // Takes the active-high pattern and drives the inverted pins.
    task automatic drive(input logic [1:0] dig_n, input logic [6:0] seg_act);
        dig_en_n = dig_n;
        seg_n    = ~seg_act;
    endtask

    initial begin
        #2;
        check("rst_hex0", hex0, 0);
        check("rst_valid0", valid0, 0);
        check("rst_upd_err", {upd, err, upd_idx}, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        clear_mon();
        run(30);
        check("idle_no_pulse", n_upd + n_err, 0);

        // Digit 0 shows "2": one update at edge 20.
        drive(2'b10, 7'h6D);
        clear_mon();
        run(40);
        check("d2_upd_count", n_upd, 1);
        check("d2_latency", first_upd, 20);
        check("d2_idx", last_idx, 0);
        check("d2_hex0", hex0, 2);
        check("d2_valid0", valid0, 1);
        check("d2_digit1_quiet", {valid1, hex1}, 0);

        // Alternate digit 0 = 4 and digit 1 = E.
        for (int k = 0; k < 2; k++) begin
            drive(2'b10, 7'h33);
            clear_mon();
            run(30);
            check("alt0_upd", n_upd, 1);
            check("alt0_idx", last_idx, 0);
            check("alt0_hex0", hex0, 4);
            drive(2'b01, 7'h4F);
            clear_mon();
            run(30);
            check("alt1_upd", n_upd, 1);
            check("alt1_idx", last_idx, 1);
            check("alt1_hex1", hex1, 14);
        end
        check("alt_valids", {valid0, valid1}, 2'b11);

        // Digit 1 = F, then an illegal pattern on digit 1.
        drive(2'b01, 7'h47);
        clear_mon();
        run(30);
        check("f_hex1", hex1, 15);
        drive(2'b01, 7'h01);
        clear_mon();
        run(30);
        check("bad_err_count", n_err, 1);
        check("bad_err_latency", first_err, 20);
        check("bad_no_upd", n_upd, 0);
        check("bad_valid1", valid1, 0);
        check("bad_hex1_kept", hex1, 15);
        check("bad_digit0_kept", {valid0, hex0}, {1'b1, 4'h4});

        // Toggling faster than the stability window.
        clear_mon();
        for (int k = 0; k < 20; k++) begin
            drive(2'b10, (k % 2 == 0) ? 7'h7E : 7'h30);
            run(10);
        end
        check("toggle_no_upd", n_upd, 0);
        check("toggle_no_err", n_err, 0);
        check("toggle_hex0", hex0, 4);

        // Both digit selects active, then none.
        drive(2'b00, 7'h6D);
        clear_mon();
        run(30);
        check("both_err", n_err, 1);
        check("both_no_upd", n_upd, 0);
        check("both_regs_kept", {hex0, hex1}, {4'h4, 4'hF});
        drive(2'b11, 7'h6D);
        clear_mon();
        run(30);
        check("blank_quiet", n_upd + n_err, 0);

        // Digit 1 = 0 held a long time: still exactly one update.
        drive(2'b01, 7'h7E);
        clear_mon();
        run(100);
        check("long_hold_upd", n_upd, 1);
        check("zero_hex1", {valid1, hex1}, {1'b1, 4'h0});
        check("zero_hex0_kept", hex0, 4);

        // Reset in the middle of a window on digit 0 = 5.
        drive(2'b10, 7'h5B);
        clear_mon();
        run(10);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_no_upd_before", n_upd, 0);
        check("midrst_outputs", {hex0, hex1, valid0, valid1, upd, err, upd_idx}, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_mon();
        run(30);
        check("postrst_latency", first_upd, 20);
        check("postrst_upd", n_upd, 1);
        check("postrst_hex0", {valid0, hex0}, {1'b1, 4'h5});
        check("postrst_digit1", {valid1, hex1}, 0);

`ifdef SEG_DECODE_ERRCNT_EN
        check("errcnt_reset", err_cnt, 0);
        clear_mon();
        for (int k = 0; k < 300; k++) begin
            drive(2'b10, (k % 2 == 0) ? 7'h01 : 7'h02);
            run(20);
        end
        check("errcnt_pulses", n_err, 300);
        check("errcnt_saturate", err_cnt, 255);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
